// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//
// Serial 8-bit UART transmitter with a small input FIFO. The producer writes
// bytes through a valid/ready handshake. Each byte goes out as one start bit
// (low), then 8 data bits LSB first, then an optional even-parity bit, then
// one stop bit (high). Every bit is held for CLKS_PER_BIT clocks.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit follows the data bits (11-bit frame)
//   undefined -> 8N1 framing (10-bit frame); no parity state or logic exists
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit, 2..65535 (default 64)
//   FIFO_DEPTH    input FIFO entries, power of two, 2..16 (default 4)
//
// Ports
//   clk_in      in   1   system clock, rising edge
//   reset       in   1   synchronous active-high reset; flushes the FIFO and
//                        abandons any frame in progress
//   tx_data     in   8   byte to send, taken when tx_valid && tx_ready
//   tx_valid    in   1   producer has a byte on tx_data
//   tx_ready    out  1   FIFO not full
//   tx_m        out  1   serial line, idle high, driven from a flop
//   busy        out  1   frame in progress or bytes still queued
//   fifo_count  out  $clog2(FIFO_DEPTH)+1   bytes queued, not counting the
//                        byte currently in the shifter
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_m,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [15:0]      BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

    // -----------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // -----------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [7:0]       head_data;

    // -----------------------------------------------------------------------
    // Transmit FSM and datapath
    // -----------------------------------------------------------------------
    state_t           state_reg,   state_next;
    logic [15:0]      baud_reg,    baud_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg,   shift_next;
    logic             tx_m_reg,    tx_m_next;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg,  parity_next;
`endif

    assign fifo_empty = (count_reg == '0);
    assign tx_ready   = (count_reg != FULL_COUNT);
    assign push       = tx_valid && tx_ready;
    assign head_data  = mem[rd_ptr_reg];

    assign tx_m       = tx_m_reg;
    assign busy       = (state_reg != ST_IDLE) || (count_reg != '0);
    assign fifo_count = count_reg;

    // Storage is written without reset: flushing only needs the pointers and
    // count cleared, stale contents are never read.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= BAUD_RELOAD;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            tx_m_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            tx_m_reg    <= tx_m_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and line-level logic.
    // The line level is derived from the current state and registered, so
    // tx_m trails the state register by exactly one clock. This places the
    // start bit on the line two edges after the push into an idle block.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        tx_m_next    = 1'b1;
        pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                tx_m_next = 1'b1;
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = head_data;
                    bit_cnt_next = '0;
                    baud_next    = BAUD_RELOAD;
                    state_next   = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_next  = ^head_data;
`endif
                end
            end

            ST_START: begin
                tx_m_next = 1'b0;
                if (baud_reg == '0) begin
                    baud_next  = BAUD_RELOAD;
                    state_next = ST_DATA;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end

            ST_DATA: begin
                tx_m_next = shift_reg[0];
                if (baud_reg == '0) begin
                    baud_next    = BAUD_RELOAD;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_m_next = parity_reg;
                if (baud_reg == '0) begin
                    baud_next  = BAUD_RELOAD;
                    state_next = ST_STOP;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
`endif

            ST_STOP: begin
                tx_m_next = 1'b1;
                if (baud_reg == '0) begin
                    baud_next = BAUD_RELOAD;
                    // Chain straight into the next frame when data is waiting,
                    // so the next start bit directly follows this stop bit.
                    if (!fifo_empty) begin
                        pop          = 1'b1;
                        shift_next   = head_data;
                        bit_cnt_next = '0;
                        state_next   = ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_next  = ^head_data;
`endif
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx at CLKS_PER_BIT = 64, FIFO_DEPTH = 4. A
// reference receiver watches tx_m, samples each bit at its centre and queues
// the recovered byte, stop bit, parity bit and start-edge cycle per frame.
// Define UART_TX_PARITY_EN for both DUT and bench to cover the parity build.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB   = 64;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CPB;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_m;
    logic       busy;
    logic [$clog2(DEPTH):0] fifo_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #10 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_m       (tx_m),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // ---------------- reference receiver ----------------
    logic [7:0] rx_q[$];
    logic       rx_stop_q[$];
    logic       rx_par_q[$];
    int         rx_t_q[$];

    logic       prev_m     = 1'b1;
    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    int         mon_start  = 0;
    logic [7:0] mon_shift  = 8'h00;
    logic       mon_par    = 1'b0;

    function automatic int mon_k(input int c);
        return (c - CPB / 2) / CPB;
    endfunction

    always @(negedge clk_in) begin
        prev_m <= tx_m;
        if (reset) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (prev_m && !tx_m) begin
                mon_active <= 1'b1;
                mon_cnt    <= 1;
                mon_start  <= cyc;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt >= CPB / 2 && ((mon_cnt - CPB / 2) % CPB) == 0) begin
                if (mon_k(mon_cnt) >= 1 && mon_k(mon_cnt) <= 8) begin
                    mon_shift[mon_k(mon_cnt) - 1] <= tx_m;
                end else if (mon_k(mon_cnt) == FB - 1) begin
                    rx_q.push_back(mon_shift);
                    rx_stop_q.push_back(tx_m);
                    rx_par_q.push_back(mon_par);
                    rx_t_q.push_back(mon_start);
                    mon_active <= 1'b0;
                end else if (mon_k(mon_cnt) == 9) begin
                    mon_par <= tx_m;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_stop_q.delete();
        rx_par_q.delete();
        rx_t_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            tick();
            t++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            tick();
            t++;
        end
    endtask

    // Expected line level for frame bit k of byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k - 1];
        if (k == FB - 1) return 1'b1;
        return ^b;
    endfunction

    logic       line_s [0:1023];
    logic [7:0] burst_b  [0:4];
    int         burst_c  [0:4];
    logic [7:0] pp_b     [0:3];

    initial begin
        int busy_cnt;
        int errs;
        int lows;

        burst_b = '{8'hA3, 8'h00, 8'hFF, 8'h3C, 8'h81};
        burst_c = '{1, 1, 2, 3, 4};
        pp_b    = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};

        // ---------------- reset with tx_valid held high ----------------
        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        tick();
        tick();
        check("rst_tx_m",   32'(tx_m), 32'd1);
        check("rst_ready",  32'(tx_ready), 32'd1);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_count",  32'(fifo_count), 32'd0);
        reset    = 1'b0;
        tx_valid = 1'b0;
        tick();
        check("post_rst_count", 32'(fifo_count), 32'd0);
        check("post_rst_busy",  32'(busy), 32'd0);

        // ---------------- single byte 0x55 ----------------
        clear_rx();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < FRAME + 4; k++) begin
            line_s[k] = tx_m;
            if (busy) busy_cnt++;
            if (k == 0) check("single_count_push", 32'(fifo_count), 32'd1);
            if (k == 1) check("single_count_pop",  32'(fifo_count), 32'd0);
            tick();
        end
        check("single_idle_before", 32'(line_s[1]), 32'd1);
        check("single_start_at2",   32'(line_s[2]), 32'd0);
        for (int b = 0; b < FB; b++) begin
            errs = 0;
            for (int j = 0; j < CPB; j++) begin
                if (line_s[2 + b * CPB + j] !== frame_bit(8'h55, b)) errs++;
            end
            check($sformatf("single_bit%0d", b), 32'(errs), 32'd0);
        end
        check("single_idle_after", 32'(line_s[2 + FRAME]), 32'd1);
        check("single_busy_cycles", 32'(busy_cnt), 32'(FRAME + 1));
        check("single_rx_byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'h55);

        // ---------------- burst of five ----------------
        clear_rx();
        for (int i = 0; i < 5; i++) begin
            tx_data  = burst_b[i];
            tx_valid = 1'b1;
            check($sformatf("burst_ready%0d", i), 32'(tx_ready), 32'd1);
            tick();
            check($sformatf("burst_count%0d", i), 32'(fifo_count), 32'(burst_c[i]));
        end
        // A sixth byte offered while full must be held off.
        tx_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            check("full_ready_low", 32'(tx_ready), 32'd0);
            tick();
            check("full_count", 32'(fifo_count), 32'd4);
        end
        tx_valid = 1'b0;
        errs = 0;
        for (int t = 0; t < 6 * FRAME && rx_q.size() < 5; t++) begin
            if (fifo_count == 4 && tx_ready !== 1'b0) errs++;
            tick();
        end
        check("burst_ready_vs_full", 32'(errs), 32'd0);
        check("burst_frames", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) begin
                check($sformatf("burst_byte%0d", i), 32'(rx_q[i]), 32'(burst_b[i]));
                check($sformatf("burst_stop%0d", i), 32'(rx_stop_q[i]), 32'd1);
`ifdef UART_TX_PARITY_EN
                check($sformatf("burst_par%0d", i), 32'(rx_par_q[i]), 32'(^burst_b[i]));
`endif
                if (i > 0) check($sformatf("burst_gap%0d", i),
                                 32'(rx_t_q[i] - rx_t_q[i - 1]), 32'(FRAME));
            end
        end
        wait_idle(4 * CPB);
        check("burst_end_busy", 32'(busy), 32'd0);
        check("burst_end_line", 32'(tx_m), 32'd1);

        // ---------------- mid-frame reset ----------------
        clear_rx();
        tx_valid = 1'b1;
        tx_data  = 8'hF0;
        tick();
        tx_data  = 8'h11;
        tick();
        tx_data  = 8'h22;
        tick();
        tx_valid = 1'b0;
        check("mid_queued", 32'(fifo_count), 32'd2);
        repeat (4 * CPB + 10) tick();
        check("mid_bit3_low", 32'(tx_m), 32'd0);
        reset = 1'b1;
        tick();
        check("mid_rst_line",  32'(tx_m), 32'd1);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        reset = 1'b0;
        lows = 0;
        for (int t = 0; t < 3 * FRAME; t++) begin
            tick();
            if (tx_m !== 1'b1) lows++;
        end
        check("mid_no_frames_line", 32'(lows), 32'd0);
        check("mid_no_frames_rx", 32'(rx_q.size()), 32'd0);

        // ---------------- push and pop together at count 2 ----------------
        clear_rx();
        tx_valid = 1'b1;
        tx_data  = pp_b[0];
        tick();
        tx_data  = pp_b[1];
        tick();
        tx_data  = pp_b[2];
        tick();
        tx_valid = 1'b0;
        check("pp_setup", 32'(fifo_count), 32'd2);
        repeat (FRAME - 2) tick();
        check("pp_before", 32'(fifo_count), 32'd2);
        tx_data  = pp_b[3];
        tx_valid = 1'b1;
        check("pp_ready", 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0;
        check("pp_after", 32'(fifo_count), 32'd2);
        wait_frames(4, 5 * FRAME);
        check("pp_frames", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size())
                check($sformatf("pp_byte%0d", i), 32'(rx_q[i]), 32'(pp_b[i]));
        end
        wait_idle(4 * CPB);
        check("pp_end_busy", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // ---------------- parity values ----------------
        clear_rx();
        tx_valid = 1'b1;
        tx_data  = 8'h07;
        tick();
        tx_data  = 8'h03;
        tick();
        tx_valid = 1'b0;
        wait_frames(2, 3 * FRAME);
        check("par_frames", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() >= 2) begin
            check("par_07", 32'(rx_par_q[0]), 32'd1);
            check("par_03", 32'(rx_par_q[1]), 32'd0);
            check("par_frame_len", 32'(rx_t_q[1] - rx_t_q[0]), 32'd704);
        end
        wait_idle(4 * CPB);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
